sd_cmd_sequencer: RTL and testbench
===================================

Name: sd_cmd_sequencer

Overview:
Issues one SD command at a time to the SD host controller over its Wishbone slave port: argument write, command write, event-status polling, response read-back, status clear. A single-entry request/done interface lets higher-level logic (init sequencer, block reader) run SD commands without driving Wishbone itself. Sits between those clients and the SD controller, as sole Wishbone master of the controller.

Parameters:
POLL_INTERVAL, 16, idle cycles (cyc low) between consecutive event-status polls; legal 1..255
POLL_LIMIT, 65535, maximum event-status polls before the sequencer declares timeout; legal 1..65535

Ports:
wb_clk_i  in  1  Wishbone clock, sole clock
wb_rst_ni  in  1  reset, asynchronous, active-low
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  sequencer idle, accepts request
cmd_index_i  in  6  SD command index
cmd_arg_i  in  32  command argument
cmd_rsp_type_i  in  4  bit0 response present, bit1 136-bit, bit2 CRC check, bit3 busy
cmd_xfer_i  in  2  data transfer: 00 none, 01 read, 10 write
done_o  out  1  one-cycle pulse: command finished
rsp_o  out  128  response words
status_o  out  6  [4:0] controller event status at completion, [5] poll timeout
sdc_wb_dat_o out 32; sdc_wb_dat_i in 32; sdc_wb_adr_o out 8; sdc_wb_sel_o out 4; sdc_wb_we_o out 1; sdc_wb_cyc_o out 1; sdc_wb_stb_o out 1; sdc_wb_ack_i in 1  Wishbone classic master to SD controller

Behaviour:
- Reset (wb_rst_ni low, async): state IDLE; cyc/stb/we=0, adr=0, dat_o=0, done_o=0, rsp_o=0, status_o=0; cmd_ready_o=0 while reset asserted. Reset mid-transaction drops cyc/stb immediately; no completion reported.
- cmd_ready_o=1 only in IDLE out of reset. Handshake at clock edge with cmd_valid_i&cmd_ready_o: capture index, arg, rsp_type, xfer; cmd_ready_o falls next cycle. Inputs ignored otherwise.
- Command word = {19'b0, index[5:0], 1'b0, xfer[1:0], rsp_type[3:0]} (index at bits 12:7).
- Event status bits: 0 complete, 1 error, 2 timeout, 3 CRC error, 4 index error.
- All Wishbone outputs registered; sel always 4'b1111. Each transaction holds cyc=stb=1 with stable adr/dat/we until ack is sampled; cyc/stb low on the following cycle; at least one idle cycle between transactions. First transaction begins the cycle after acceptance.
- States, in order: WR_ARG (write 0x00 = arg) -> WR_CMD (write 0x04 = command word) -> POLL (read 0x34) -> [WAIT] -> RD_RSP -> CLR (write 0x34 = 0) -> DONE -> IDLE.
- POLL: if read data bit0 or bit1 set, latch data[4:0] into status and exit POLL; else increment poll count; if count reaches POLL_LIMIT set timeout flag and go to CLR; else WAIT POLL_INTERVAL cycles with cyc low, then re-poll. Poll count 16 bits, cleared at acceptance.
- RD_RSP runs only when rsp_type bit0=1 and event status bit1=0 and no timeout. 48-bit: read 0x08 -> rsp[31:0], rsp[127:32]=0. 136-bit: read 0x08, 0x0C, 0x10, 0x14 -> rsp[31:0], [63:32], [95:64], [127:96]. Otherwise rsp=0.
- CLR always executes (also after timeout or error).
- DONE: done_o=1 for exactly one cycle, the cycle after the CLR ack is sampled; rsp_o and status_o update in that same cycle and hold until the next done_o. cmd_ready_o returns to 1 the cycle after done_o.
- ack arriving while cyc low is ignored. No retries: error reporting only.

Test Plan:
- CMD0, arg 0, rsp_type 0, slave acks 1 cycle after stb, status reads 0x01 on first poll -> bus trace: W 0x00=0, W 0x04=0x00000000, R 0x34, W 0x34=0; done_o single pulse; rsp_o=0, status_o=0x01.
- CMD8, arg 0x1AA, rsp_type 0b0101, status 0 for 3 polls then 0x01, RESPONSE_0=0x000001AA -> command word 0x405; 4 polls spaced >=POLL_INTERVAL idle cycles; rsp_o[31:0]=0x1AA, upper bits 0.
- CMD2, rsp_type 0b0111, response registers 0x11111111/0x22222222/0x33333333/0x44444444 -> four reads in address order; rsp_o=0x44444444_33333333_22222222_11111111.
- Status 0x06 (error+timeout) with rsp present -> no response reads; CLR issued; status_o=0x06, rsp_o=0.
- POLL_LIMIT=4, status never sets bit0/bit1 -> exactly 4 polls, CLR, status_o[5]=1; cmd_valid_i held high during busy not accepted until cmd_ready_o returns.
- Reset pulsed while WR_CMD awaits ack -> cyc/stb low asynchronously, no done_o; after release cmd_ready_o=1 and next command runs from WR_ARG.

Source files
------------

// File: rtl/sd_cmd_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_cmd_sequencer : runs one SD command over the controller's Wishbone port
// rev 1.0
// ---------------------------------------------------------------------------
module sd_cmd_sequencer #(
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned POLL_LIMIT    = 65535
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [5:0]   cmd_index_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [3:0]   cmd_rsp_type_i,
  input  logic [1:0]   cmd_xfer_i,
  output logic         done_o,
  output logic [127:0] rsp_o,
  output logic [5:0]   status_o,
  output logic [31:0]  sdc_wb_dat_o,
  input  logic [31:0]  sdc_wb_dat_i,
  output logic [7:0]   sdc_wb_adr_o,
  output logic [3:0]   sdc_wb_sel_o,
  output logic         sdc_wb_we_o,
  output logic         sdc_wb_cyc_o,
  output logic         sdc_wb_stb_o,
  input  logic         sdc_wb_ack_i
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_WR_ARG = 4'd1,
    S_WR_CMD = 4'd2,
    S_POLL   = 4'd3,
    S_WAIT   = 4'd4,
    S_RD_RSP = 4'd5,
    S_CLR    = 4'd6,
    S_DONE   = 4'd7
  } state_e;

  localparam logic [15:0] C_POLL_LIMIT    = 16'(POLL_LIMIT);
  localparam logic [7:0]  C_POLL_INTERVAL = 8'(POLL_INTERVAL);
  localparam logic [7:0]  C_ADR_ARG       = 8'h00;
  localparam logic [7:0]  C_ADR_CMD       = 8'h04;
  localparam logic [7:0]  C_ADR_RSP0      = 8'h08;
  localparam logic [7:0]  C_ADR_EVT       = 8'h34;

  state_e         state_q, state_d;
  logic           ready_q, ready_d;
  logic           cyc_q, cyc_d;
  logic           we_q, we_d;
  logic [7:0]     adr_q, adr_d;
  logic [31:0]    dat_q, dat_d;
  logic           gap_q, gap_d;
  logic [5:0]     index_q, index_d;
  logic [31:0]    arg_q, arg_d;
  logic [3:0]     rsp_type_q, rsp_type_d;
  logic [1:0]     xfer_q, xfer_d;
  logic [15:0]    poll_cnt_q, poll_cnt_d;
  logic [7:0]     wait_cnt_q, wait_cnt_d;
  logic [1:0]     rsp_idx_q, rsp_idx_d;
  logic [127:0]   acc_q, acc_d;
  logic [4:0]     ev_q, ev_d;
  logic           tmo_q, tmo_d;
  logic           done_q, done_d;
  logic [127:0]   rsp_q, rsp_d;
  logic [5:0]     status_q, status_d;

  logic           bus_state;
  logic           ack;
  logic [7:0]     tgt_adr;
  logic [31:0]    tgt_dat;
  logic           tgt_we;
  logic [31:0]    cmd_word;

  assign ack      = cyc_q & sdc_wb_ack_i;
  assign cmd_word = {19'b0, index_q, 1'b0, xfer_q, rsp_type_q};

  always_comb begin
    tgt_adr   = 8'h00;
    tgt_dat   = 32'h0;
    tgt_we    = 1'b0;
    bus_state = 1'b1;
    case (state_q)
      S_WR_ARG: begin tgt_adr = C_ADR_ARG; tgt_dat = arg_q; tgt_we = 1'b1; end
      S_WR_CMD: begin tgt_adr = C_ADR_CMD; tgt_dat = cmd_word; tgt_we = 1'b1; end
      S_POLL:   tgt_adr = C_ADR_EVT;
      S_RD_RSP: tgt_adr = C_ADR_RSP0 + {4'b0, rsp_idx_q, 2'b00};
      S_CLR:    begin tgt_adr = C_ADR_EVT; tgt_we = 1'b1; end
      default:  bus_state = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    gap_d      = gap_q;
    index_d    = index_q;
    arg_d      = arg_q;
    rsp_type_d = rsp_type_q;
    xfer_d     = xfer_q;
    poll_cnt_d = poll_cnt_q;
    wait_cnt_d = wait_cnt_q;
    rsp_idx_d  = rsp_idx_q;
    acc_d      = acc_q;
    ev_d       = ev_q;
    tmo_d      = tmo_q;
    done_d     = 1'b0;
    rsp_d      = rsp_q;
    status_d   = status_q;

    // gap_q forces one idle cycle between back-to-back transactions
    if (bus_state && !cyc_q) begin
      if (gap_q) begin
        gap_d = 1'b0;
      end else begin
        cyc_d = 1'b1;
        adr_d = tgt_adr;
        dat_d = tgt_dat;
        we_d  = tgt_we;
      end
    end
    if (ack) begin
      cyc_d = 1'b0;
      gap_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          index_d    = cmd_index_i;
          arg_d      = cmd_arg_i;
          rsp_type_d = cmd_rsp_type_i;
          xfer_d     = cmd_xfer_i;
          poll_cnt_d = 16'd0;
          rsp_idx_d  = 2'd0;
          acc_d      = '0;
          ev_d       = 5'd0;
          tmo_d      = 1'b0;
          state_d    = S_WR_ARG;
          cyc_d      = 1'b1;
          we_d       = 1'b1;
          adr_d      = C_ADR_ARG;
          dat_d      = cmd_arg_i;
          gap_d      = 1'b0;
        end
      end
      S_WR_ARG: if (ack) state_d = S_WR_CMD;
      S_WR_CMD: if (ack) state_d = S_POLL;
      S_POLL: begin
        if (ack) begin
          if (sdc_wb_dat_i[0] || sdc_wb_dat_i[1]) begin
            ev_d    = sdc_wb_dat_i[4:0];
            state_d = (rsp_type_q[0] && !sdc_wb_dat_i[1]) ? S_RD_RSP : S_CLR;
          end else begin
            poll_cnt_d = poll_cnt_q + 16'd1;
            if (poll_cnt_q + 16'd1 == C_POLL_LIMIT) begin
              tmo_d   = 1'b1;
              state_d = S_CLR;
            end else begin
              wait_cnt_d = C_POLL_INTERVAL;
              state_d    = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        // launch on the last idle cycle so exactly POLL_INTERVAL idle cycles elapse
        if (wait_cnt_q <= 8'd1) begin
          state_d = S_POLL;
          cyc_d   = 1'b1;
          gap_d   = 1'b0;
          we_d    = 1'b0;
          adr_d   = C_ADR_EVT;
          dat_d   = 32'h0;
        end else begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end
      end
      S_RD_RSP: begin
        if (ack) begin
          acc_d[rsp_idx_q*32 +: 32] = sdc_wb_dat_i;
          if (rsp_type_q[1] && rsp_idx_q != 2'd3) begin
            rsp_idx_d = rsp_idx_q + 2'd1;
          end else begin
            state_d = S_CLR;
          end
        end
      end
      S_CLR: begin
        if (ack) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          rsp_d    = acc_q;
          status_d = {tmo_q, ev_q};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= 8'h00;
      dat_q      <= 32'h0;
      gap_q      <= 1'b0;
      index_q    <= 6'd0;
      arg_q      <= 32'h0;
      rsp_type_q <= 4'd0;
      xfer_q     <= 2'd0;
      poll_cnt_q <= 16'd0;
      wait_cnt_q <= 8'd0;
      rsp_idx_q  <= 2'd0;
      acc_q      <= '0;
      ev_q       <= 5'd0;
      tmo_q      <= 1'b0;
      done_q     <= 1'b0;
      rsp_q      <= '0;
      status_q   <= 6'd0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      gap_q      <= gap_d;
      index_q    <= index_d;
      arg_q      <= arg_d;
      rsp_type_q <= rsp_type_d;
      xfer_q     <= xfer_d;
      poll_cnt_q <= poll_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      rsp_idx_q  <= rsp_idx_d;
      acc_q      <= acc_d;
      ev_q       <= ev_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      rsp_q      <= rsp_d;
      status_q   <= status_d;
    end
  end

  assign cmd_ready_o  = ready_q;
  assign done_o       = done_q;
  assign rsp_o        = rsp_q;
  assign status_o     = status_q;
  assign sdc_wb_dat_o = dat_q;
  assign sdc_wb_adr_o = adr_q;
  assign sdc_wb_sel_o = 4'hF;
  assign sdc_wb_we_o  = we_q;
  assign sdc_wb_cyc_o = cyc_q;
  assign sdc_wb_stb_o = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sd_cmd_sequencer : directed bench with a Wishbone slave model and bus log
// rev 1.0
// ---------------------------------------------------------------------------
module tb_sd_cmd_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_arg = '0;
  logic [3:0]   cmd_rsp_type = '0;
  logic [1:0]   cmd_xfer = '0;
  logic         done;
  logic [127:0] rsp;
  logic [5:0]   status;
  logic [31:0]  wb_dat_o, wb_dat_i;
  logic [7:0]   wb_adr;
  logic [3:0]   wb_sel;
  logic         wb_we, wb_cyc, wb_stb;
  logic         ack_q = 1'b0;

  always #5 clk = ~clk;

  sd_cmd_sequencer #(.POLL_INTERVAL(3), .POLL_LIMIT(4)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_index_i(cmd_index), .cmd_arg_i(cmd_arg),
    .cmd_rsp_type_i(cmd_rsp_type), .cmd_xfer_i(cmd_xfer),
    .done_o(done), .rsp_o(rsp), .status_o(status),
    .sdc_wb_dat_o(wb_dat_o), .sdc_wb_dat_i(wb_dat_i), .sdc_wb_adr_o(wb_adr),
    .sdc_wb_sel_o(wb_sel), .sdc_wb_we_o(wb_we), .sdc_wb_cyc_o(wb_cyc),
    .sdc_wb_stb_o(wb_stb), .sdc_wb_ack_i(ack_q)
  );

  // slave model: acks one cycle after stb, logs each transaction
  int          log_n = 0, idle_run = 0, poll_num = 0, done_cnt = 0, acc_cnt = 0;
  logic        log_we  [0:127];
  logic [7:0]  log_adr [0:127];
  logic [31:0] log_dat [0:127];
  int          log_idle[0:127];
  int          n_zero = 0, poll_base = 0;
  logic [31:0] final_stat = 32'h1;
  logic [31:0] rsp_reg [0:3];

  always_comb begin
    wb_dat_i = 32'hDEADBEEF;
    case (wb_adr)
      8'h34: wb_dat_i = ((poll_num - poll_base) < n_zero) ? 32'h0 : final_stat;
      8'h08: wb_dat_i = rsp_reg[0];
      8'h0C: wb_dat_i = rsp_reg[1];
      8'h10: wb_dat_i = rsp_reg[2];
      8'h14: wb_dat_i = rsp_reg[3];
      default: wb_dat_i = 32'hDEADBEEF;
    endcase
  end

  always @(posedge clk) begin
    if (wb_cyc && wb_stb && !ack_q) begin
      if (log_n < 128) begin
        log_we[log_n]   <= wb_we;
        log_adr[log_n]  <= wb_adr;
        log_dat[log_n]  <= wb_dat_o;
        log_idle[log_n] <= idle_run;
      end
      log_n <= log_n + 1;
      ack_q <= 1'b1;
    end else begin
      ack_q <= 1'b0;
    end
    if (wb_cyc && ack_q && wb_adr == 8'h34 && !wb_we) poll_num <= poll_num + 1;
    if (!wb_cyc) idle_run <= idle_run + 1;
    else         idle_run <= 0;
    if (done) done_cnt <= done_cnt + 1;
    if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    chk("ready_wait", 128'(cmd_ready), 128'(1));
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg,
                       input logic [3:0] rt, input logic [1:0] xf);
    wait_ready();
    cmd_index = idx; cmd_arg = arg; cmd_rsp_type = rt; cmd_xfer = xf;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 2000) begin @(negedge clk); t++; end
    chk("done_seen", 128'(done), 128'(1));
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [7:0] adr, input logic [31:0] dat);
    chk(tag, {87'b0, log_we[i], log_adr[i], log_dat[i]}, {87'b0, 1'b1, adr, dat});
  endtask

  task automatic chk_rd(input string tag, input int i, input logic [7:0] adr);
    chk(tag, {119'b0, log_we[i], log_adr[i]}, {119'b0, 1'b0, adr});
  endtask

  int base, d0, a0;

  initial begin
    rsp_reg[0] = 32'h0; rsp_reg[1] = 32'h0; rsp_reg[2] = 32'h0; rsp_reg[3] = 32'h0;

    // reset state
    tick(3);
    chk("rst_cyc",    128'({wb_cyc, wb_stb, wb_we}), 128'(0));
    chk("rst_ready",  128'(cmd_ready), 128'(0));
    chk("rst_outs",   {rsp, 1'b0, done, status} , 136'(0) >> 8);
    chk("rst_adrdat", 128'({wb_adr, wb_dat_o}), 128'(0));
    chk("sel",        128'(wb_sel), 128'(4'hF));
    rst_n = 1'b1;
    tick(2);
    chk("ready_after_rst", 128'(cmd_ready), 128'(1));

    // CMD0, no response, complete on first poll
    base = log_n; poll_base = poll_num; n_zero = 0; final_stat = 32'h1; d0 = done_cnt;
    issue(6'd0, 32'h0, 4'b0000, 2'b00);
    wait_done();
    chk("cmd0_rsp", rsp, 128'(0));
    chk("cmd0_status", 128'(status), 128'(6'h01));
    tick(3);
    chk("cmd0_ntx", 128'(log_n - base), 128'(4));
    chk_wr("cmd0_arg", base + 0, 8'h00, 32'h0);
    chk_wr("cmd0_cmd", base + 1, 8'h04, 32'h0);
    chk_rd("cmd0_poll", base + 2, 8'h34);
    chk_wr("cmd0_clr", base + 3, 8'h34, 32'h0);
    chk("cmd0_done_pulses", 128'(done_cnt - d0), 128'(1));
    chk("cmd0_ready_back", 128'(cmd_ready), 128'(1));

    // CMD8, 48-bit response, three empty polls before completion
    base = log_n; poll_base = poll_num; n_zero = 3; final_stat = 32'h1;
    rsp_reg[0] = 32'h000001AA;
    issue(6'd8, 32'h1AA, 4'b0101, 2'b00);
    wait_done();
    chk("cmd8_rsp", rsp, 128'h1AA);
    chk("cmd8_status", 128'(status), 128'(6'h01));
    tick(3);
    chk("cmd8_ntx", 128'(log_n - base), 128'(8));
    chk_wr("cmd8_arg", base + 0, 8'h00, 32'h1AA);
    chk_wr("cmd8_cmd", base + 1, 8'h04, 32'h405);
    for (int i = 2; i < 6; i++) chk_rd("cmd8_poll", base + i, 8'h34);
    for (int i = 3; i < 6; i++) chk("cmd8_poll_gap", 128'(log_idle[base + i] >= 3), 128'(1));
    chk_rd("cmd8_rsp0", base + 6, 8'h08);
    chk_wr("cmd8_clr", base + 7, 8'h34, 32'h0);

    // CMD2, 136-bit response, read transfer field
    base = log_n; poll_base = poll_num; n_zero = 0; final_stat = 32'h1;
    rsp_reg[0] = 32'h11111111; rsp_reg[1] = 32'h22222222;
    rsp_reg[2] = 32'h33333333; rsp_reg[3] = 32'h44444444;
    issue(6'd2, 32'h0, 4'b0111, 2'b01);
    wait_done();
    chk("cmd2_rsp", rsp, 128'h44444444_33333333_22222222_11111111);
    tick(3);
    chk("cmd2_ntx", 128'(log_n - base), 128'(8));
    chk_wr("cmd2_cmd", base + 1, 8'h04, 32'h117);
    chk_rd("cmd2_r0", base + 3, 8'h08);
    chk_rd("cmd2_r1", base + 4, 8'h0C);
    chk_rd("cmd2_r2", base + 5, 8'h10);
    chk_rd("cmd2_r3", base + 6, 8'h14);
    chk_wr("cmd2_clr", base + 7, 8'h34, 32'h0);

    // error + timeout event status: no response reads, clear still issued
    base = log_n; poll_base = poll_num; n_zero = 0; final_stat = 32'h6;
    issue(6'd5, 32'h12345678, 4'b0001, 2'b00);
    wait_done();
    chk("err_status", 128'(status), 128'(6'h06));
    chk("err_rsp", rsp, 128'(0));
    tick(3);
    chk("err_ntx", 128'(log_n - base), 128'(4));
    chk_wr("err_arg", base + 0, 8'h00, 32'h12345678);
    chk_wr("err_cmd", base + 1, 8'h04, 32'h281);
    chk_wr("err_clr", base + 3, 8'h34, 32'h0);

    // poll limit reached, cmd_valid held high while busy
    base = log_n; poll_base = poll_num; n_zero = 1000; final_stat = 32'h1;
    wait_ready();
    a0 = acc_cnt;
    cmd_index = 6'd1; cmd_arg = 32'h0; cmd_rsp_type = 4'b0001; cmd_xfer = 2'b00;
    cmd_valid = 1'b1;
    @(negedge clk);
    wait_done();
    chk("tmo_accepts_busy", 128'(acc_cnt - a0), 128'(1));
    cmd_valid = 1'b0;
    chk("tmo_status", 128'(status), 128'(6'h20));
    chk("tmo_rsp", rsp, 128'(0));
    tick(1);
    chk("tmo_ready_back", 128'(cmd_ready), 128'(1));
    tick(2);
    chk("tmo_accepts_after", 128'(acc_cnt - a0), 128'(1));
    chk("tmo_ntx", 128'(log_n - base), 128'(7));
    for (int i = 2; i < 6; i++) chk_rd("tmo_poll", base + i, 8'h34);
    chk_wr("tmo_clr", base + 6, 8'h34, 32'h0);

    // reset while the command write awaits ack
    n_zero = 0; final_stat = 32'h1; d0 = done_cnt;
    issue(6'd3, 32'hAAAA, 4'b0001, 2'b00);
    begin
      int t = 0;
      while (!(wb_cyc && wb_adr == 8'h04) && t < 50) begin @(negedge clk); t++; end
      chk("rst_mid_reach_cmd", 128'(wb_cyc && wb_adr == 8'h04), 128'(1));
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", 128'({wb_cyc, wb_stb}), 128'(0));
    chk("rst_mid_ready", 128'(cmd_ready), 128'(0));
    tick(5);
    chk("rst_mid_no_done", 128'(done_cnt - d0), 128'(0));
    rst_n = 1'b1;
    tick(2);
    chk("rst_mid_ready_back", 128'(cmd_ready), 128'(1));
    base = log_n; poll_base = poll_num;
    issue(6'd0, 32'h0, 4'b0000, 2'b00);
    wait_done();
    chk("rst_mid_status", 128'(status), 128'(6'h01));
    tick(3);
    chk("rst_mid_done_pulses", 128'(done_cnt - d0), 128'(1));
    chk("rst_mid_ntx", 128'(log_n - base), 128'(4));
    chk_wr("rst_mid_arg", base + 0, 8'h00, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
